data_mem_responder: RTL

- Responder (slave) end of the core's data-memory port: accepts load/store requests issued by the core's load/store stage and answers them.
- Decodes DataAccess size, address offset and signedness into byte masks and lane alignment.
- Holds a word-organised on-chip RAM, inserts a programmable number of wait states, and signals alignment/range errors.
- Sits between the core's memory stage and local data RAM.

---
 rtl/data_mem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte-lane decode and programmable wait states; one request in flight,
// ack arrives 2+WAIT_STATES cycles after the request is sampled, and i_req is held until o_ack (no other backpressure).
module data_mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            i_access,
    input  logic                  i_wrEnable,
    input  logic                  i_unsigned,
    input  logic [DATA_WIDTH-1:0] i_wrData,
    output logic                  o_ack,
    output logic [DATA_WIDTH-1:0] o_rdData,
    output logic                  o_error,
    output logic                  o_busy
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-3:0] MEM_LIMIT = (ADDR_WIDTH-2)'(MEM_WORDS);
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

    localparam logic [1:0] ACC_BYTE = 2'd0;
    localparam logic [1:0] ACC_HALF = 2'd1;
    localparam logic [1:0] ACC_WORD = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [1:0]             access_q;
    logic                   wr_q;
    logic                   uns_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic [DATA_WIDTH-1:0]  mem_q [MEM_WORDS];

    logic [IDX_W-1:0]       word_idx;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic [DATA_WIDTH-1:0]  shifted;
    logic [3:0]             mask_c;
    logic [DATA_WIDTH-1:0]  wrep_c;
    logic [DATA_WIDTH-1:0]  load_c;
    logic                   sign_c;
    logic                   misalign_c;
    logic                   range_err_c;
    logic                   err_c;

    assign word_idx    = addr_q[IDX_W+1:2];
    assign rd_word     = mem_q[word_idx];
    assign shifted     = rd_word >> {addr_q[1:0], 3'b000};
    assign range_err_c = (addr_q[ADDR_WIDTH-1:2] >= MEM_LIMIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (i_req) state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
            end
            S_WAIT: begin
                if (cnt_q == WS_LAST) begin
                    state_d = S_ACCESS;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Lane decode: stores replicate narrow data across lanes so the mask alone picks the byte(s).
    always_comb begin
        misalign_c = 1'b0;
        mask_c     = 4'b0000;
        wrep_c     = wdata_q;
        load_c     = '0;
        sign_c     = 1'b0;
        case (access_q)
            ACC_BYTE: begin
                mask_c = 4'b0001 << addr_q[1:0];
                wrep_c = {4{wdata_q[7:0]}};
                sign_c = ~uns_q & shifted[7];
                load_c = {{24{sign_c}}, shifted[7:0]};
            end
            ACC_HALF: begin
                misalign_c = addr_q[0];
                mask_c     = 4'b0011 << addr_q[1:0];
                wrep_c     = {2{wdata_q[15:0]}};
                sign_c     = ~uns_q & shifted[15];
                load_c     = {{16{sign_c}}, shifted[15:0]};
            end
            ACC_WORD: begin
                misalign_c = |addr_q[1:0];
                mask_c     = 4'b1111;
                load_c     = shifted;
            end
            default: misalign_c = 1'b1;
        endcase
        err_c = misalign_c | range_err_c;
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (state_q == S_ACCESS) begin
            err_d   = err_c;
            rdata_d = (err_c || wr_q) ? '0 : load_c;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            access_q <= 2'd0;
            wr_q     <= 1'b0;
            uns_q    <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == S_IDLE && i_req) begin
                addr_q   <= i_addr;
                access_q <= i_access;
                wr_q     <= i_wrEnable;
                uns_q    <= i_unsigned;
                wdata_q  <= i_wrData;
            end
        end
    end

    // RAM is never reset; reset forces IDLE, which already blocks any write.
    always_ff @(posedge i_clock) begin
        if (state_q == S_ACCESS && wr_q && !err_c) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_c[b]) mem_q[word_idx][8*b +: 8] <= wrep_c[8*b +: 8];
            end
        end
    end

    assign o_ack    = (state_q == S_RESP);
    assign o_busy   = (state_q == S_WAIT) || (state_q == S_ACCESS);
    assign o_rdData = rdata_q;
    assign o_error  = err_q;

endmodule
